nios_system_clkgen: RTL and testbench

- Parametrised multi-channel digital clock generator: NUM_CH phase-coherent divided clock waveforms plus one-cycle enable strobes, all derived from one input clock.
- Per-channel divide ratio, duty (high time) and phase offset are runtime-programmable through a write/apply interface.
- Provides a PLL-style `locked` status with a programmable settle delay.
- Sits beside the system PLL and feeds slow peripheral timebases (LED scan, UART tick, SDRAM refresh tick) without spending further PLL outputs.

---
 rtl/nios_system_clkgen.sv | 155 +++++++++++++++
 tb/tb_nios_system_clkgen.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/nios_system_clkgen.sv
// Multi-channel phase-coherent clock divider with a write/apply configuration port and a PLL-style lock flag.
// Optional: define CLKGEN_GATE_UNLOCKED_EN to hold outclk/outclk_en low until locked.
module nios_system_clkgen #(
    parameter  int NUM_CH      = 2,
    parameter  int CNT_W       = 16,
    parameter  int LOCK_CYCLES = 16,
    parameter  int DEF_DIV     = 2,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_high,
    input  logic [CNT_W-1:0]  cfg_phase,
    input  logic              cfg_apply,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] outclk,
    output logic [NUM_CH-1:0] outclk_en,
    output logic              locked
);

    localparam int LK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LK_W-1:0]  LOCK_INIT  = LK_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEF_DIV_C  = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] DEF_HIGH_C = CNT_W'(DEF_DIV / 2);
    localparam logic [CH_W:0]    NUM_CH_C   = (CH_W + 1)'(NUM_CH);

    typedef enum logic [1:0] {
        ST_RESET,
        ST_ALIGN,
        ST_LOCKING,
        ST_LOCKED
    } state_t;

    state_t            state_reg, state_next;
    logic [LK_W-1:0]   lock_cnt_reg, lock_cnt_next;
    logic              locked_reg;
    logic              cfg_err_reg;
    logic              cfg_fire, cfg_bad, wr_ok;
    logic              show_next;
    logic              count_now;

    assign cfg_ready = (state_reg != ST_RESET);
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign cfg_bad   = (cfg_div == '0) || (cfg_high > cfg_div) || (cfg_phase >= cfg_div)
                    || ({1'b0, cfg_ch} >= NUM_CH_C);
    assign wr_ok     = cfg_fire && !cfg_bad;
    assign count_now = (state_reg == ST_LOCKING) || (state_reg == ST_LOCKED);

    always_comb begin
        state_next    = state_reg;
        lock_cnt_next = lock_cnt_reg;
        case (state_reg)
            ST_RESET: state_next = ST_ALIGN;
            ST_ALIGN: begin
                state_next    = ST_LOCKING;
                lock_cnt_next = LOCK_INIT;
            end
            ST_LOCKING: begin
                if (cfg_apply) begin
                    state_next = ST_ALIGN;
                end else if (lock_cnt_reg == '0) begin
                    state_next = ST_LOCKED;
                end else begin
                    lock_cnt_next = lock_cnt_reg - 1'b1;
                end
            end
            ST_LOCKED: begin
                if (cfg_apply) begin
                    state_next = ST_ALIGN;
                end
            end
            default: state_next = ST_RESET;
        endcase
    end

    // Outputs are registered from next-cycle values so they line up with the counter they describe.
`ifdef CLKGEN_GATE_UNLOCKED_EN
    assign show_next = (state_next == ST_LOCKED);
`else
    assign show_next = (state_next == ST_LOCKING) || (state_next == ST_LOCKED);
`endif

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_reg    <= ST_RESET;
            lock_cnt_reg <= '0;
            locked_reg   <= 1'b0;
            cfg_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            lock_cnt_reg <= lock_cnt_next;
            locked_reg   <= (state_next == ST_LOCKED);
            cfg_err_reg  <= cfg_fire && cfg_bad;
        end
    end

    assign locked  = locked_reg;
    assign cfg_err = cfg_err_reg;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [CNT_W-1:0] sh_div_reg, sh_high_reg, sh_phase_reg;
        logic [CNT_W-1:0] div_reg, high_reg, cnt_reg;
        logic [CNT_W-1:0] div_next, high_next, cnt_next;
        logic             out_reg, en_reg;
        logic             wr_hit;

        assign wr_hit = wr_ok && (cfg_ch == CH_W'(gi));

        always_comb begin
            div_next  = div_reg;
            high_next = high_reg;
            cnt_next  = cnt_reg;
            if (state_reg == ST_ALIGN) begin
                // Pre-load (div - phase) mod div so the period start lands phase cycles late.
                div_next  = sh_div_reg;
                high_next = sh_high_reg;
                cnt_next  = (sh_phase_reg == '0) ? '0 : sh_div_reg - sh_phase_reg;
            end else if (count_now) begin
                cnt_next = (cnt_reg == div_reg - 1'b1) ? '0 : cnt_reg + 1'b1;
            end
        end

        always_ff @(posedge refclk) begin
            if (rst) begin
                sh_div_reg   <= DEF_DIV_C;
                sh_high_reg  <= DEF_HIGH_C;
                sh_phase_reg <= '0;
                div_reg      <= DEF_DIV_C;
                high_reg     <= DEF_HIGH_C;
                cnt_reg      <= '0;
                out_reg      <= 1'b0;
                en_reg       <= 1'b0;
            end else begin
                if (wr_hit) begin
                    sh_div_reg   <= cfg_div;
                    sh_high_reg  <= cfg_high;
                    sh_phase_reg <= cfg_phase;
                end
                div_reg  <= div_next;
                high_reg <= high_next;
                cnt_reg  <= cnt_next;
                out_reg  <= show_next && (cnt_next < high_next);
                en_reg   <= show_next && (cnt_next == '0);
            end
        end

        assign outclk[gi]    = out_reg;
        assign outclk_en[gi] = en_reg;
    end

endmodule

// File: tb/tb_nios_system_clkgen.sv
// Randomized bench for nios_system_clkgen: a timestamp-based reference model predicts every output each cycle.
module tb_nios_system_clkgen;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 16;
    localparam int LOCK   = 16;
    localparam int DEFDIV = 2;
    localparam int CH_W   = 2;

    logic              refclk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [CNT_W-1:0]  cfg_div = '0;
    logic [CNT_W-1:0]  cfg_high = '0;
    logic [CNT_W-1:0]  cfg_phase = '0;
    logic              cfg_apply = 1'b0;
    logic              cfg_err;
    logic [NUM_CH-1:0] outclk;
    logic [NUM_CH-1:0] outclk_en;
    logic              locked;

    nios_system_clkgen #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .LOCK_CYCLES(LOCK), .DEF_DIV(DEFDIV)
    ) dut (
        .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_phase(cfg_phase),
        .cfg_apply(cfg_apply), .cfg_err(cfg_err), .outclk(outclk), .outclk_en(outclk_en),
        .locked(locked)
    );

    always #5 refclk = ~refclk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: shadow/active settings plus the edge numbers at which alignment began and counters were loaded.
    int sdiv[NUM_CH], shigh[NUM_CH], sphase[NUM_CH];
    int adiv[NUM_CH], ahigh[NUM_CH], aphase[NUM_CH];
    int  edge_n     = 0;
    int  align_edge = -10;
    int  load_edge  = -100;
    bit  in_reset   = 1'b1;
    bit  err_exp    = 1'b0;

`ifdef CLKGEN_GATE_UNLOCKED_EN
    localparam bit GATE = 1'b1;
`else
    localparam bit GATE = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
    endtask

    function automatic bit is_bad(int ch, int dv, int hi, int ph);
        return (dv == 0) || (hi > dv) || (ph >= dv) || (ch >= NUM_CH);
    endfunction

    task automatic tick();
        bit was_reset;
        logic [NUM_CH-1:0] e_out, e_en;
        bit e_lock, running;
        int k, c;
        @(posedge refclk);
        edge_n++;
        was_reset = in_reset;
        if (rst) begin
            in_reset = 1'b1;
            err_exp  = 1'b0;
            align_edge = -10;
            load_edge  = -100;
            for (int i = 0; i < NUM_CH; i++) begin
                sdiv[i] = DEFDIV; shigh[i] = DEFDIV / 2; sphase[i] = 0;
                adiv[i] = DEFDIV; ahigh[i] = DEFDIV / 2; aphase[i] = 0;
            end
        end else begin
            err_exp = cfg_valid && !was_reset && is_bad(cfg_ch, cfg_div, cfg_high, cfg_phase);
            if (was_reset) begin
                in_reset   = 1'b0;
                align_edge = edge_n;
            end else if (align_edge == edge_n - 1) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    adiv[i] = sdiv[i]; ahigh[i] = shigh[i]; aphase[i] = sphase[i];
                end
                load_edge = edge_n;
            end else if (cfg_apply) begin
                align_edge = edge_n;
            end
            if (cfg_valid && !was_reset && !is_bad(cfg_ch, cfg_div, cfg_high, cfg_phase)) begin
                sdiv[cfg_ch] = cfg_div; shigh[cfg_ch] = cfg_high; sphase[cfg_ch] = cfg_phase;
            end
        end
        #1;
        running = !in_reset && (load_edge > align_edge);
        e_lock  = running && (edge_n - align_edge >= LOCK + 1);
        for (int i = 0; i < NUM_CH; i++) begin
            k = edge_n - load_edge;
            c = (adiv[i] - aphase[i] + k) % adiv[i];
            e_out[i] = running && (!GATE || e_lock) && (c < ahigh[i]);
            e_en[i]  = running && (!GATE || e_lock) && (c == 0);
        end
        check("outclk",    32'(outclk),    32'(e_out));
        check("outclk_en", 32'(outclk_en), 32'(e_en));
        check("locked",    32'(locked),    32'(e_lock));
        check("cfg_err",   32'(cfg_err),   32'(err_exp));
        check("cfg_ready", 32'(cfg_ready), 32'(!in_reset));
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic cfg_write(input int ch, input int dv, input int hi, input int ph, input bit ap);
        cfg_valid = 1'b1; cfg_ch = CH_W'(ch); cfg_div = CNT_W'(dv);
        cfg_high = CNT_W'(hi); cfg_phase = CNT_W'(ph); cfg_apply = ap;
        $display("cfg write ch=%0d div=%0d high=%0d phase=%0d apply=%0d", ch, dv, hi, ph, ap);
        tick();
        cfg_valid = 1'b0; cfg_apply = 1'b0;
    endtask

    task automatic apply();
        cfg_apply = 1'b1;
        $display("cfg apply");
        tick();
        cfg_apply = 1'b0;
    endtask

    task automatic reset_pulse(input int cycles);
        rst = 1'b1;
        $display("reset for %0d cycles", cycles);
        idle(cycles);
        rst = 1'b0;
    endtask

    initial begin
        int r;
        reset_pulse(3);
        idle(30);

        // ch1 lags ch0 by 3 cycles; write and apply share a cycle.
        cfg_write(0, 5, 2, 0, 1'b0);
        cfg_write(1, 5, 2, 3, 1'b1);
        idle(30);

        cfg_write(0, 0, 0, 0, 1'b0);
        cfg_write(0, 5, 6, 0, 1'b0);
        cfg_write(1, 5, 2, 5, 1'b0);
        cfg_write(3, 4, 1, 0, 1'b0);
        apply();
        idle(30);

        apply();
        idle(10);
        apply();
        idle(25);

        cfg_write(2, 7, 3, 4, 1'b1);
        idle(25);
        reset_pulse(1);
        idle(25);

        cfg_write(0, 1, 1, 0, 1'b0);
        cfg_write(1, 1, 0, 0, 1'b0);
        cfg_write(2, 3, 3, 2, 1'b1);
        idle(25);

        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 19);
            if (r < 10) begin
                cfg_write($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 8),
                          $urandom_range(0, 7), ($urandom_range(0, 3) == 0));
            end else if (r < 14) begin
                apply();
            end else if (r == 14) begin
                reset_pulse($urandom_range(1, 2));
            end
            idle($urandom_range(0, 22));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
